systolic_ctrl: RTL

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array tile controller: state encoding
// and the skewed compute length of a DIM x DIM x DIM tile.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int DEFAULT_DIM = 8;

    // A skewed DIM-deep reduction needs DIM-1 fill steps on each side of the DIM
    // useful steps before the last partial product reaches the far corner.
    function automatic int compute_steps(input int dim);
        return 3 * dim - 2;
    endfunction

    localparam int COMPUTE_STEPS = compute_steps(DEFAULT_DIM);

endpackage

// File: rtl/systolic_ctrl.sv
// Sequencer for one systolic tile operation: optional accumulator clear, skewed
// compute under feeder flow control, then row-by-row readout under consumer flow control.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int DIM    = 8,
    parameter int BITS_C = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      acc,
    input  logic                      abort,
    input  logic                      feed_ready,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      arr_en,
    output logic                      arr_wren,
    output logic                      clr_sel,
    output logic [$clog2(DIM)-1:0]    arr_crow,
    output logic [$clog2(3*DIM)-1:0]  feed_k,
    output logic                      out_valid
);

    localparam int RW = $clog2(DIM);
    localparam int KW = $clog2(3 * DIM);
    localparam logic [RW-1:0] LAST_ROW  = RW'(DIM - 1);
    localparam logic [KW-1:0] LAST_STEP = KW'(compute_steps(DIM) - 1);

    if (DIM < 2 || BITS_C < 1) begin : g_param_check
        $error("systolic_ctrl: DIM must be >= 2 and BITS_C >= 1");
    end

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [KW-1:0]   step_q, step_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            step_q  <= step_d;
        end
    end

    // Outputs are decoded from the current state only, except arr_en which
    // follows feed_ready so the array never shifts without operands.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        step_d    = step_q;
        busy      = 1'b1;
        done      = 1'b0;
        arr_en    = 1'b0;
        arr_wren  = 1'b0;
        clr_sel   = 1'b0;
        arr_crow  = '0;
        feed_k    = '0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = acc ? COMPUTE : CLEAR;
                end
            end
            CLEAR: begin
                arr_wren = 1'b1;
                clr_sel  = 1'b1;
                arr_crow = row_q;
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = COMPUTE;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            COMPUTE: begin
                arr_en = feed_ready;
                feed_k = step_q;
                if (feed_ready) begin
                    if (step_q == LAST_STEP) begin
                        step_d  = '0;
                        row_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        step_d = step_q + KW'(1);
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                arr_crow  = row_q;
                if (out_ready) begin
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
                row_d   = '0;
                step_d  = '0;
            end
        endcase

        // Cancel wins over every transition above; rst is handled in the register.
        if (abort) begin
            state_d = IDLE;
            row_d   = '0;
            step_d  = '0;
        end
    end

endmodule
